// File: rtl/clock_freeze_ctrl_pkg.sv
// Shared definitions for the clock-freeze consumer path: FSM state codes,
// default debounce length and counter width helper.
package clock_freeze_ctrl_pkg;

    typedef enum logic [1:0] {
        CLKFRZ_RUN    = 2'd0,
        CLKFRZ_FROZEN = 2'd1,
        CLKFRZ_STEP   = 2'd2
    } clkfrz_state_e;

    // 20 ms at 50 MHz
    localparam int unsigned CLKFRZ_DEBOUNCE = 1000000;

    // Bits needed to count 0 .. n-1, never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_freeze_ctrl_button_debounce.sv
// Generic board-button conditioner: 2-flop synchronizer, debounce counter
// and rising-edge detect on the accepted level.
module button_debounce
    import clock_freeze_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = CLKFRZ_DEBOUNCE
) (
    input  logic clock50,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock50) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn_in;
            sync2    <= sync1;
            stable_d <= stable;
            // Any cycle agreeing with the stable level restarts the count.
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign btn_level = stable;
    assign btn_rise  = stable & ~stable_d;

endmodule

// File: rtl/clock_freeze_ctrl.sv
// Core clock-enable generator: divided-rate enable in RUN, held in FROZEN,
// one enable cycle per debounced step press.
module clock_freeze_ctrl
    import clock_freeze_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = CLKFRZ_DEBOUNCE,
    parameter int unsigned DIV_RATIO       = 1
) (
    input  logic clock50,
    input  logic rst,
    input  logic freeze_req,
    input  logic step_btn,
    output logic core_clk_en,
    output logic frozen
);

    localparam int unsigned DW = cnt_width(DIV_RATIO);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);

    clkfrz_state_e state;
    clkfrz_state_e state_nx;
    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nx;
    logic          en_q;
    logic          frozen_q;
    logic          step_edge;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clock50  (clock50),
        .rst      (rst),
        .btn_in   (step_btn),
        .btn_level(),
        .btn_rise (step_edge)
    );

    always_comb begin
        state_nx = state;
        div_nx   = '0;
        unique case (state)
            CLKFRZ_RUN:    if (freeze_req) state_nx = CLKFRZ_FROZEN;
            CLKFRZ_FROZEN: begin
                if (freeze_req)     state_nx = CLKFRZ_RUN;
                else if (step_edge) state_nx = CLKFRZ_STEP;
            end
            CLKFRZ_STEP:   state_nx = freeze_req ? CLKFRZ_RUN : CLKFRZ_FROZEN;
            default:       state_nx = CLKFRZ_RUN;
        endcase
        // Divider only advances while staying in RUN; any entry into RUN starts at 0.
        if (state == CLKFRZ_RUN && state_nx == CLKFRZ_RUN)
            div_nx = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end

    // Outputs are registered from the next-state decode so they match the
    // state/div_cnt held during the following cycle.
    always_ff @(posedge clock50) begin
        if (!rst) begin
            state    <= CLKFRZ_RUN;
            div_cnt  <= '0;
            en_q     <= (DIV_RATIO == 1);
            frozen_q <= 1'b0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_nx;
            en_q     <= (state_nx == CLKFRZ_STEP) ||
                        (state_nx == CLKFRZ_RUN && div_nx == DIV_LAST);
            frozen_q <= (state_nx != CLKFRZ_RUN);
        end
    end

    assign core_clk_en = rst & en_q;
    assign frozen      = rst & frozen_q;

endmodule

// File: tb/tb_clock_freeze_ctrl.sv
// Directed bench for clock_freeze_ctrl with DEBOUNCE_CYCLES=4, DIV_RATIO=3:
// a vector table for reset/divider/freeze/step, then multi-cycle corner sequences.
module tb_clock_freeze_ctrl;

    logic clock50 = 1'b0;
    logic rst = 1'b0;
    logic freeze_req = 1'b0;
    logic step_btn = 1'b0;
    logic core_clk_en;
    logic frozen;

    int tests = 0;
    int failed = 0;
    int cyc_n = 0;

    typedef struct {
        logic r;
        logic f;
        logic b;
        logic en;
        logic fr;
    } vec_t;

    vec_t vecs[$];

    clock_freeze_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DIV_RATIO      (3)
    ) dut (
        .clock50    (clock50),
        .rst        (rst),
        .freeze_req (freeze_req),
        .step_btn   (step_btn),
        .core_clk_en(core_clk_en),
        .frozen     (frozen)
    );

    always #5 clock50 = ~clock50;

    function automatic void add(input logic r, f, b, en, fr);
        vec_t v;
        v.r = r; v.f = f; v.b = b; v.en = en; v.fr = fr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s idx %0d (cycle %0d): got %b expected %b", name, idx, cyc_n, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then check that cycle's outputs.
    task automatic step_cycle(input string name, input int idx, input logic r, f, b,
                              input logic exp_en, exp_fr);
        @(negedge clock50);
        rst        = r;
        freeze_req = f;
        step_btn   = b;
        #1;
        chk({name, ".en"}, idx, core_clk_en, exp_en);
        chk({name, ".frozen"}, idx, frozen, exp_fr);
        cyc_n++;
    endtask

    initial begin
        // Reset for 5 cycles, then RUN with pulses on the 3rd, 6th, 9th cycle.
        for (int k = 0; k < 5; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) add(1'b1, (k == 8), 1'b0, (k % 3 == 2), 1'b0);
        // Frozen idle.
        for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // Clean 20-cycle press: single pulse 7 edges after the first sampling edge.
        for (int k = 0; k < 20; k++) add(1'b1, 1'b0, 1'b1, (k == 7), 1'b1);
        // Release must debounce; no pulse.
        for (int k = 0; k < 16; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i])
            step_cycle("table", i, vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].en, vecs[i].fr);

        // Bounce 1,1,0,0,1,1,0,0 then hold: pulse timed from the final high (idx 8).
        for (int i = 0; i < 22; i++) begin
            logic b;
            b = (i >= 8) ? 1'b1 : ((i % 4) < 2);
            step_cycle("bounce", i, 1'b1, 1'b0, b, (i == 15), 1'b1);
        end
        for (int i = 0; i < 12; i++) step_cycle("bounce_rel", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // freeze_req coincident with step_edge (idx 6); then a step pressed in RUN
        // is ignored; freeze at idx 50 with the button still held produces no step.
        for (int i = 0; i < 71; i++) begin
            logic b, f, en, fr;
            b  = (i < 20) || (i >= 32);
            f  = (i == 6) || (i == 50);
            fr = (i <= 6) || (i > 50);
            en = (i >= 7 && i <= 50) ? ((i - 7) % 3 == 2) : 1'b0;
            step_cycle("collide_run", i, 1'b1, f, b, en, fr);
        end
        for (int i = 0; i < 12; i++) step_cycle("collide_rel", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // freeze_req during STEP: pulse still occurs, then RUN.
        for (int i = 0; i < 15; i++) begin
            logic en, fr;
            fr = (i <= 7) || (i == 14 && 1'b0);
            en = (i == 7) || (i >= 8 && ((i - 8) % 3 == 2));
            step_cycle("step_unfreeze", i, 1'b1, (i == 7) || (i == 14), 1'b1, en, fr);
        end

        // Unfreeze from FROZEN: first pulse 3 cycles after the request.
        for (int i = 0; i < 12; i++) begin
            logic en, fr;
            fr = (i <= 4);
            en = (i >= 5) && ((i - 5) % 3 == 2);
            step_cycle("unfreeze", i, 1'b1, (i == 4) || (i == 11), 1'b0, en, fr);
        end

        // Reset during debounce aborts the pending step.
        for (int i = 0; i < 31; i++) begin
            logic r, b, en, fr;
            r  = !(i == 4 || i == 5);
            b  = (i < 4);
            fr = (i < 4) || (i > 14);
            en = (i >= 6 && i <= 14) ? ((i - 6) % 3 == 2) : 1'b0;
            step_cycle("rst_abort", i, r, (i == 14), b, en, fr);
        end

        // Long frozen idle: enable stays low for 50 cycles.
        for (int i = 0; i < 50; i++) step_cycle("frozen_hold", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
